// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: groups the LSB data port, the instruction-fetch port, the
// byte-wide RAM port and the run/flush/UART-status controls of mem_ctrl.
//   master : the requester side (LSB, fetch unit, RAM model, pipeline control)
//   slave  : the memory controller itself
interface mem_ctrl_if;
  // pipeline control
  logic        rdy_in;
  logic        clear_flag;
  // LSB data port
  logic        full_mem;
  logic [31:0] addr;
  logic [31:0] data;
  logic        load_or_store;
  logic [1:0]  size;
  logic        is_signed;
  logic        mem_ready;
  logic [31:0] mem_val;
  // instruction fetch port
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  // byte-wide RAM port
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  // UART status
  logic        io_buffer_full;

  modport master (
    output rdy_in, clear_flag, full_mem, addr, data, load_or_store, size,
           is_signed, if_valid, if_addr, ram_din, io_buffer_full,
    input  mem_ready, mem_val, if_ready, if_data, ram_dout, ram_a, ram_wr
  );

  modport slave (
    input  rdy_in, clear_flag, full_mem, addr, data, load_or_store, size,
           is_signed, if_valid, if_addr, ram_din, io_buffer_full,
    output mem_ready, mem_val, if_ready, if_data, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises 1/2/4-byte loads, stores and word instruction fetches
// onto a byte-wide RAM whose read data arrives one cycle after the address.
// Ports:
//   clk_in : clock, all state updates on the rising edge
//   rst_in : asynchronous active-low reset
//   bus    : mem_ctrl_if.slave (controls, LSB port, fetch port, RAM port)
module mem_ctrl (
  input  logic       clk_in,
  input  logic       rst_in,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  // control / output registers (reset)
  state_t      state_q, state_n;
  logic [2:0]  cnt_q, cnt_n;        // edges since acceptance, for the next edge
  logic [2:0]  nbytes_q, nbytes_n;
  logic        fetch_q, fetch_n;
  logic [31:0] ram_a_q, ram_a_n;
  logic [7:0]  ram_dout_q, ram_dout_n;
  logic        ram_wr_q, ram_wr_n;
  logic        mem_ready_q, mem_ready_n;
  logic [31:0] mem_val_q, mem_val_n;
  logic        if_ready_q, if_ready_n;
  logic [31:0] if_data_q, if_data_n;

  // request data registers (no reset needed)
  logic [31:0] base_q, base_n;
  logic [31:0] wdata_q, wdata_n;
  logic [23:0] rbuf_q, rbuf_n;      // bytes 0..2 of a read in flight
  logic        sext_q, sext_n;

  logic        io_block;
  logic [31:0] raw_word;

  function automatic logic [2:0] byte_count(input logic [1:0] sz);
    case (sz)
      2'd0:    byte_count = 3'd1;
      2'd1:    byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                              input logic [2:0]  n,
                                              input logic        sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = raw[7:0];
    h = raw[15:0];
    if (n == 3'd1)
      w = sgn ? b : $signed({24'd0, raw[7:0]});
    else if (n == 3'd2)
      w = sgn ? h : $signed({16'd0, raw[15:0]});
    else
      w = $signed(raw);
    load_extend = $unsigned(w);
  endfunction

  // A store to the UART window must wait while its buffer is full.
  assign io_block = bus.load_or_store && (bus.addr[17:16] == 2'b11) &&
                    bus.io_buffer_full;

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    nbytes_n    = nbytes_q;
    fetch_n     = fetch_q;
    ram_a_n     = ram_a_q;
    ram_dout_n  = ram_dout_q;
    ram_wr_n    = ram_wr_q;
    mem_ready_n = mem_ready_q;
    mem_val_n   = mem_val_q;
    if_ready_n  = if_ready_q;
    if_data_n   = if_data_q;
    base_n      = base_q;
    wdata_n     = wdata_q;
    rbuf_n      = rbuf_q;
    sext_n      = sext_q;
    raw_word    = 32'd0;

    unique case (state_q)
      IDLE: begin
        ram_wr_n = 1'b0;
        if (!bus.clear_flag && !mem_ready_q && !if_ready_q) begin
          // Data request has priority; a blocked store also holds off fetches.
          if (bus.full_mem) begin
            if (!io_block) begin
              fetch_n  = 1'b0;
              base_n   = bus.addr;
              wdata_n  = bus.data;
              sext_n   = bus.is_signed;
              nbytes_n = byte_count(bus.size);
              cnt_n    = 3'd1;
              ram_a_n  = bus.addr;
              if (bus.load_or_store) begin
                ram_dout_n = bus.data[7:0];
                ram_wr_n   = 1'b1;
                state_n    = WRITE;
              end else begin
                state_n    = READ;
              end
            end
          end else if (bus.if_valid) begin
            fetch_n  = 1'b1;
            base_n   = bus.if_addr;
            sext_n   = 1'b0;
            nbytes_n = 3'd4;
            cnt_n    = 3'd1;
            ram_a_n  = bus.if_addr;
            state_n  = READ;
          end
        end
      end

      READ: begin
        if (bus.clear_flag) begin
          state_n = IDLE;
        end else begin
          // address phase runs one edge ahead of the data phase
          if (cnt_q < nbytes_q)
            ram_a_n = base_q + {29'd0, cnt_q};
          if (cnt_q <= nbytes_q) begin
            case (cnt_q)
              3'd2:    rbuf_n[7:0]   = bus.ram_din;
              3'd3:    rbuf_n[15:8]  = bus.ram_din;
              3'd4:    rbuf_n[23:16] = bus.ram_din;
              default: ;
            endcase
          end
          if (cnt_q == nbytes_q + 3'd1) begin
            // last byte is taken straight from ram_din on this edge
            if (nbytes_q == 3'd1)
              raw_word = {24'd0, bus.ram_din};
            else if (nbytes_q == 3'd2)
              raw_word = {16'd0, bus.ram_din, rbuf_q[7:0]};
            else
              raw_word = {bus.ram_din, rbuf_q};
            if (fetch_q) begin
              if_data_n  = raw_word;
              if_ready_n = 1'b1;
            end else begin
              mem_val_n   = load_extend(raw_word, nbytes_q, sext_q);
              mem_ready_n = 1'b1;
            end
            state_n = DONE;
          end
          cnt_n = cnt_q + 3'd1;
        end
      end

      // A store is already committed, so a flush does not interrupt it.
      WRITE: begin
        if (cnt_q < nbytes_q) begin
          ram_a_n = base_q + {29'd0, cnt_q};
          case (cnt_q)
            3'd1:    ram_dout_n = wdata_q[15:8];
            3'd2:    ram_dout_n = wdata_q[23:16];
            default: ram_dout_n = wdata_q[31:24];
          endcase
          cnt_n = cnt_q + 3'd1;
        end else begin
          ram_wr_n    = 1'b0;
          mem_ready_n = 1'b1;
          mem_val_n   = 32'd0;
          state_n     = DONE;
        end
      end

      DONE: begin
        mem_ready_n = 1'b0;
        if_ready_n  = 1'b0;
        state_n     = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      nbytes_q    <= 3'd0;
      fetch_q     <= 1'b0;
      ram_a_q     <= 32'd0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_val_q   <= 32'd0;
      if_ready_q  <= 1'b0;
      if_data_q   <= 32'd0;
    end else if (bus.rdy_in) begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      nbytes_q    <= nbytes_n;
      fetch_q     <= fetch_n;
      ram_a_q     <= ram_a_n;
      ram_dout_q  <= ram_dout_n;
      ram_wr_q    <= ram_wr_n;
      mem_ready_q <= mem_ready_n;
      mem_val_q   <= mem_val_n;
      if_ready_q  <= if_ready_n;
      if_data_q   <= if_data_n;
    end
  end

  always_ff @(posedge clk_in) begin
    if (bus.rdy_in) begin
      base_q  <= base_n;
      wdata_q <= wdata_n;
      rbuf_q  <= rbuf_n;
      sext_q  <= sext_n;
    end
  end

  assign bus.ram_a     = ram_a_q;
  assign bus.ram_dout  = ram_dout_q;
  // while paused the held byte must not be written repeatedly
  assign bus.ram_wr    = ram_wr_q & bus.rdy_in;
  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_val   = mem_val_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_data   = if_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a byte-wide RAM model whose
// read data lags the address by one cycle.
module tb_mem_ctrl;

  logic clk_in;
  logic rst_in;
  int   vectors;
  int   errs;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // RAM model: preload image plus a separate written image
  logic [7:0] init_mem [0:4095];
  logic [7:0] wmem     [0:4095];
  bit         wvalid   [0:4095];

  always @(posedge clk_in) begin
    bus.ram_din <= wvalid[bus.ram_a[11:0]] ? wmem[bus.ram_a[11:0]]
                                           : init_mem[bus.ram_a[11:0]];
    if (bus.ram_wr) begin
      wmem[bus.ram_a[11:0]]   <= bus.ram_dout;
      wvalid[bus.ram_a[11:0]] <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic st, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] sz,
                     input logic sg);
    bus.load_or_store = st;
    bus.addr          = a;
    bus.data          = d;
    bus.size          = sz;
    bus.is_signed     = sg;
    bus.full_mem      = 1'b1;
  endtask

  // Load: ready expected exactly at edge rdy_edge after acceptance.
  task automatic load_check(input string tag, input logic [31:0] a,
                            input logic [1:0] sz, input logic sg,
                            input int rdy_edge, input logic [31:0] exp);
    logic early;
    early = 1'b0;
    req(1'b0, a, 32'd0, sz, sg);
    tick();
    chk({tag, "_a0"}, bus.ram_a, a);
    for (int e = 1; e < rdy_edge; e++) begin
      tick();
      early = early | bus.mem_ready;
    end
    chk({tag, "_early"}, {31'd0, early}, 32'd0);
    tick();
    chk({tag, "_rdy"}, {31'd0, bus.mem_ready}, 32'd1);
    chk({tag, "_val"}, bus.mem_val, exp);
    bus.full_mem = 1'b0;
    tick();
    chk({tag, "_pulse"}, {31'd0, bus.mem_ready}, 32'd0);
  endtask

  initial begin
    logic seen;
    vectors = 0;
    errs    = 0;
    for (int i = 0; i < 4096; i++) init_mem[i] = 8'h00;
    init_mem[12'h100] = 8'h11; init_mem[12'h101] = 8'h22;
    init_mem[12'h102] = 8'h33; init_mem[12'h103] = 8'h44;
    init_mem[12'h110] = 8'h80;
    init_mem[12'h120] = 8'h01; init_mem[12'h121] = 8'h80;
    init_mem[12'hFFF] = 8'hA1; init_mem[12'h000] = 8'hB2;
    init_mem[12'h001] = 8'hC3; init_mem[12'h002] = 8'hD4;

    rst_in             = 1'b0;
    bus.rdy_in         = 1'b1;
    bus.clear_flag     = 1'b0;
    bus.full_mem       = 1'b0;
    bus.addr           = 32'd0;
    bus.data           = 32'd0;
    bus.load_or_store  = 1'b0;
    bus.size           = 2'd0;
    bus.is_signed      = 1'b0;
    bus.if_valid       = 1'b0;
    bus.if_addr        = 32'd0;
    bus.io_buffer_full = 1'b0;

    // reset state
    #12;
    chk("rst_ram_a", bus.ram_a, 32'd0);
    chk("rst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    chk("rst_ram_dout", {24'd0, bus.ram_dout}, 32'd0);
    chk("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
    chk("rst_mem_val", bus.mem_val, 32'd0);
    chk("rst_if_ready", {31'd0, bus.if_ready}, 32'd0);
    chk("rst_if_data", bus.if_data, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();

    // loads of each width and sign mode
    load_check("lw", 32'h100, 2'd2, 1'b0, 5, 32'h44332211);
    load_check("lb_s", 32'h110, 2'd0, 1'b1, 2, 32'hFFFFFF80);
    load_check("lbu", 32'h110, 2'd0, 1'b0, 2, 32'h00000080);
    load_check("lhu", 32'h120, 2'd1, 1'b0, 3, 32'h00008001);
    load_check("lh_s", 32'h120, 2'd1, 1'b1, 3, 32'hFFFF8001);
    load_check("lw_wrap", 32'hFFFFFFFF, 2'd2, 1'b0, 5, 32'hD4C3B2A1);

    // store word, full_mem held through DONE
    req(1'b1, 32'h200, 32'hAABBCCDD, 2'd2, 1'b0);
    tick();
    chk("sw_wr0", {31'd0, bus.ram_wr}, 32'd1);
    chk("sw_a0", bus.ram_a, 32'h200);
    chk("sw_d0", {24'd0, bus.ram_dout}, 32'hDD);
    tick();
    chk("sw_a1", bus.ram_a, 32'h201);
    chk("sw_d1", {24'd0, bus.ram_dout}, 32'hCC);
    tick();
    chk("sw_d2", {24'd0, bus.ram_dout}, 32'hBB);
    tick();
    chk("sw_a3", bus.ram_a, 32'h203);
    chk("sw_d3", {24'd0, bus.ram_dout}, 32'hAA);
    chk("sw_wr3", {31'd0, bus.ram_wr}, 32'd1);
    chk("sw_rdy3", {31'd0, bus.mem_ready}, 32'd0);
    tick();
    chk("sw_wr4", {31'd0, bus.ram_wr}, 32'd0);
    chk("sw_rdy4", {31'd0, bus.mem_ready}, 32'd1);
    chk("sw_val4", bus.mem_val, 32'd0);
    tick();
    chk("sw_done_rdy", {31'd0, bus.mem_ready}, 32'd0);
    chk("sw_done_noacc", {31'd0, bus.ram_wr}, 32'd0);
    bus.full_mem = 1'b0;
    tick();
    chk("sw_mem", {wmem[12'h203], wmem[12'h202], wmem[12'h201], wmem[12'h200]},
        32'hAABBCCDD);

    // data and fetch together: load first, fetch after DONE
    req(1'b0, 32'h110, 32'd0, 2'd0, 1'b0);
    bus.if_valid = 1'b1;
    bus.if_addr  = 32'h100;
    tick();
    chk("prio_a0", bus.ram_a, 32'h110);
    tick();
    tick();
    chk("prio_ld_rdy", {31'd0, bus.mem_ready}, 32'd1);
    chk("prio_ld_val", bus.mem_val, 32'h80);
    chk("prio_if_rdy", {31'd0, bus.if_ready}, 32'd0);
    bus.full_mem = 1'b0;
    tick();
    chk("prio_done_a", bus.ram_a, 32'h110);
    tick();
    chk("prio_if_a", bus.ram_a, 32'h100);
    for (int e = 5; e < 9; e++) tick();
    tick();
    chk("if_rdy", {31'd0, bus.if_ready}, 32'd1);
    chk("if_data", bus.if_data, 32'h44332211);
    bus.if_valid = 1'b0;
    tick();
    chk("if_pulse", {31'd0, bus.if_ready}, 32'd0);

    // flush during a word load: no pulse
    seen = 1'b0;
    req(1'b0, 32'h100, 32'd0, 2'd2, 1'b0);
    tick();
    tick();
    seen = seen | bus.mem_ready;
    bus.clear_flag = 1'b1;
    bus.full_mem   = 1'b0;
    tick();
    bus.clear_flag = 1'b0;
    for (int e = 0; e < 8; e++) begin
      seen = seen | bus.mem_ready;
      tick();
    end
    chk("clr_ld_noready", {31'd0, seen}, 32'd0);

    // flush during a word store: store completes
    req(1'b1, 32'h210, 32'h11223344, 2'd2, 1'b0);
    tick();
    tick();
    bus.clear_flag = 1'b1;
    tick();
    tick();
    bus.clear_flag = 1'b0;
    chk("clr_st_a3", bus.ram_a, 32'h213);
    chk("clr_st_wr3", {31'd0, bus.ram_wr}, 32'd1);
    tick();
    chk("clr_st_rdy", {31'd0, bus.mem_ready}, 32'd1);
    bus.full_mem = 1'b0;
    tick();
    chk("clr_st_mem", {wmem[12'h213], wmem[12'h212], wmem[12'h211], wmem[12'h210]},
        32'h11223344);

    // UART-window store held off while the buffer is full
    seen = 1'b0;
    req(1'b1, 32'h00030000, 32'h0000005A, 2'd0, 1'b0);
    bus.io_buffer_full = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      seen = seen | bus.ram_wr;
    end
    chk("io_hold_wr", {31'd0, seen}, 32'd0);
    bus.io_buffer_full = 1'b0;
    tick();
    chk("io_wr", {31'd0, bus.ram_wr}, 32'd1);
    chk("io_a", bus.ram_a, 32'h00030000);
    chk("io_d", {24'd0, bus.ram_dout}, 32'h5A);
    tick();
    chk("io_rdy", {31'd0, bus.mem_ready}, 32'd1);
    chk("io_wr_end", {31'd0, bus.ram_wr}, 32'd0);
    bus.full_mem = 1'b0;
    tick();

    // pause mid-store
    req(1'b1, 32'h220, 32'h0000BEEF, 2'd1, 1'b0);
    tick();
    chk("frz_d0", {24'd0, bus.ram_dout}, 32'hEF);
    bus.rdy_in = 1'b0;
    #1;
    chk("frz_wr_gate", {31'd0, bus.ram_wr}, 32'd0);
    tick();
    tick();
    chk("frz_a_hold", bus.ram_a, 32'h220);
    chk("frz_wr_hold", {31'd0, bus.ram_wr}, 32'd0);
    bus.rdy_in = 1'b1;
    #1;
    chk("frz_wr_resume", {31'd0, bus.ram_wr}, 32'd1);
    tick();
    chk("frz_a1", bus.ram_a, 32'h221);
    chk("frz_d1", {24'd0, bus.ram_dout}, 32'hBE);
    tick();
    chk("frz_rdy", {31'd0, bus.mem_ready}, 32'd1);
    bus.full_mem = 1'b0;
    tick();
    chk("frz_mem", {16'd0, wmem[12'h221], wmem[12'h220]}, 32'h0000BEEF);

    // flush in IDLE blocks acceptance for that cycle
    req(1'b1, 32'h240, 32'h00000077, 2'd0, 1'b0);
    bus.clear_flag = 1'b1;
    tick();
    chk("clr_idle_wr", {31'd0, bus.ram_wr}, 32'd0);
    bus.clear_flag = 1'b0;
    tick();
    chk("clr_idle_acc", {31'd0, bus.ram_wr}, 32'd1);
    chk("clr_idle_a", bus.ram_a, 32'h240);
    tick();
    bus.full_mem = 1'b0;
    tick();

    // asynchronous reset in the middle of a store
    req(1'b1, 32'h230, 32'hCAFEF00D, 2'd2, 1'b0);
    tick();
    tick();
    chk("ar_wr_before", {31'd0, bus.ram_wr}, 32'd1);
    #2;
    rst_in       = 1'b0;
    bus.full_mem = 1'b0;
    #1;
    chk("ar_wr", {31'd0, bus.ram_wr}, 32'd0);
    chk("ar_a", bus.ram_a, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();
    tick();
    chk("ar_no_resume", {31'd0, bus.ram_wr}, 32'd0);
    chk("ar_no_rdy", {31'd0, bus.mem_ready}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
